// File: rtl/xbar_out_arbmux.sv
// Crossbar output port: round-robin packet arbiter with a registered output stage.
// An input keeps ownership of the output from grant until its last beat is accepted.

module xbar_out_arbmux_lane (
    input  logic owner,
    input  logic accept,
    input  logic valid,
    output logic ready,
    output logic xfer
);
    assign ready = owner & accept;
    assign xfer  = ready & valid;
endmodule

module xbar_out_arbmux #(
    parameter int N_IN   = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_IN-1:0]          in_valid,
    input  logic [N_IN*DATA_W-1:0]   in_data,
    input  logic [N_IN-1:0]          in_last,
    output logic [N_IN-1:0]          in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [N_IN-1:0]          grant,
    output logic                     busy
);
    localparam int PTR_W = $clog2(N_IN);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic [0:0]                   state;
    logic [N_IN-1:0]              grant_q;
    logic [PTR_W-1:0]             last_ptr;
    logic                         out_valid_q;
    beat_t                        out_q;

    logic [N_IN-1:0][DATA_W-1:0]  in_data_a;
    logic                         accept;
    logic [N_IN-1:0]              xfer_v;
    logic                         xfer;
    beat_t                        sel;

    logic                         win_found;
    logic [PTR_W-1:0]             win_idx;
    logic [N_IN-1:0]              win_onehot;
    int                           cand;

    assign in_data_a = in_data;

    // The output register can take a beat when it is empty or draining this cycle.
    assign accept = !out_valid_q || out_ready;

    for (genvar i = 0; i < N_IN; i++) begin : g_lane
        xbar_out_arbmux_lane u_lane (
            .owner  (grant_q[i]),
            .accept (accept),
            .valid  (in_valid[i]),
            .ready  (in_ready[i]),
            .xfer   (xfer_v[i])
        );
    end

    assign xfer = |xfer_v;

    // grant_q is one-hot while locked, so an AND-OR mux selects the owner's beat.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (grant_q[i]) begin
                sel.data = sel.data | in_data_a[i];
                sel.last = sel.last | in_last[i];
            end
        end
    end

    // Round-robin search starting just after the previous owner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= N_IN; k++) begin
            cand = (int'(last_ptr) + k) % N_IN;
            if (!win_found && in_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
    end

    assign win_onehot = N_IN'(1) << win_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            grant_q  <= '0;
            last_ptr <= PTR_W'(N_IN - 1);
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        grant_q  <= win_onehot;
                        last_ptr <= win_idx;
                        state    <= S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    if (xfer && sel.last) begin
                        grant_q <= '0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_q       <= sel;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_q.data;
    assign out_last  = out_q.last;
    assign grant     = grant_q;
    assign busy      = (state == S_LOCKED);

    a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
    a_busy_grant   : assert property (@(posedge clk) disable iff (!rst_n) busy == (|grant_q));

endmodule

// File: tb/tb_xbar_out_arbmux.sv
// Bench for xbar_out_arbmux: directed vector table and sequences, then random
// traffic checked every cycle against a transaction-level model and a scoreboard.

module tb_xbar_out_arbmux;
    localparam int N = 4;
    localparam int W = 8;

    typedef struct packed {
        logic         last;
        logic [W-1:0] data;
    } beat_t;

    typedef struct {
        logic         ordy;
        logic [N-1:0] g;
        logic         ov;
        logic [W-1:0] od;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_last = '0;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           out_ready = 1'b0;
    logic [N-1:0]   grant;
    logic           busy;

    xbar_out_arbmux #(.N_IN(N), .DATA_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Source side: one queue of pending beats per input, gated by en.
    beat_t        q[N][$];
    logic [N-1:0] en;
    logic [W-1:0] log_q[$];
    int           stamp[$];
    int           cyc_n = 0;

    // Transaction-level model of the output port.
    int           m_owner;
    int           m_last;
    logic         m_ov;
    logic         m_ol;
    logic [W-1:0] m_od;

    // Scoreboard for random traffic.
    logic         sb_on = 1'b0;
    logic [5:0]   gen_seq[N];
    logic [5:0]   exp_seq[N];
    int           cur_src;
    int           starve[N];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_pkt(input int i, input int len);
        for (int b = 0; b < len; b++) begin
            q[i].push_back({(b == len - 1), 2'(i), gen_seq[i]});
            gen_seq[i] = gen_seq[i] + 6'd1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = '0;
        out_ready = 1'b0;
        #1;
        m_owner = -1; m_last = N - 1; m_ov = 1'b0; m_od = '0; m_ol = 1'b0;
        for (int i = 0; i < N; i++) q[i].delete();
        log_q.delete();
        stamp.delete();
        en = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive, compare against model, clock, advance model and sources.
    task automatic cyc(input logic ordy);
        logic [N-1:0] v;
        logic [N-1:0] eg;
        logic [N-1:0] er;
        logic         pbusy;
        logic [18:0]  act;
        logic [18:0]  exp;
        int           o;
        int           src;
        logic         found;
        v = '0;
        for (int i = 0; i < N; i++) begin
            in_data[i*W +: W] = '0;
            in_last[i] = 1'b0;
            if (en[i] && q[i].size() > 0) begin
                v[i] = 1'b1;
                in_data[i*W +: W] = q[i][0].data;
                in_last[i] = q[i][0].last;
            end
        end
        in_valid = v;
        out_ready = ordy;
        #1;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        er = (m_owner >= 0 && (!m_ov || ordy)) ? eg : '0;
        act = {grant, busy, out_valid, out_last, out_data, in_ready};
        exp = {eg, (m_owner >= 0), m_ov, m_ol, m_od, er};
        chk("cycle", 64'(act), 64'(exp));
        if (out_valid && ordy) begin
            log_q.push_back(out_data);
            stamp.push_back(cyc_n);
            if (sb_on) begin
                src = int'(out_data[7:6]);
                chk("sb_seq", 64'(out_data[5:0]), 64'(exp_seq[src]));
                exp_seq[src] = out_data[5:0] + 6'd1;
                if (cur_src >= 0) chk("sb_whole_pkt", 64'(src), 64'(cur_src));
                cur_src = out_last ? -1 : src;
            end
        end
        pbusy = busy;
        @(posedge clk);
        o = m_owner;
        if (o < 0) begin
            if (m_ov && ordy) m_ov = 1'b0;
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                if (!found && v[(m_last + k) % N]) begin
                    found = 1'b1;
                    m_owner = (m_last + k) % N;
                    m_last = m_owner;
                end
            end
        end else if (v[o] && er[o]) begin
            m_ov = 1'b1;
            m_od = q[o][0].data;
            m_ol = q[o][0].last;
            if (q[o][0].last) m_owner = -1;
            void'(q[o].pop_front());
        end else if (m_ov && ordy) begin
            m_ov = 1'b0;
        end
        cyc_n++;
        #1;
        if (sb_on && !pbusy && busy) begin
            for (int i = 0; i < N; i++) begin
                if (grant[i] || !v[i]) starve[i] = 0;
                else begin
                    starve[i]++;
                    chk("starve_bound", 64'(starve[i] <= N - 1), 64'(1));
                end
            end
        end
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 4'b0001, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 4'b0000, 1'b1, 8'h10};
        tbl[2] = '{1'b1, 4'b0010, 1'b0, 8'h10};
        tbl[3] = '{1'b1, 4'b0000, 1'b1, 8'h11};
        tbl[4] = '{1'b1, 4'b0100, 1'b0, 8'h11};
        tbl[5] = '{1'b1, 4'b0000, 1'b1, 8'h12};
        tbl[6] = '{1'b1, 4'b1000, 1'b0, 8'h12};
        tbl[7] = '{1'b1, 4'b0000, 1'b1, 8'h13};
        tbl[8] = '{1'b1, 4'b0001, 1'b0, 8'h13};
        tbl[9] = '{1'b1, 4'b0000, 1'b1, 8'h20};
        for (int i = 0; i < N; i++) begin gen_seq[i] = '0; exp_seq[i] = '0; starve[i] = 0; end
        cur_src = -1;

        // Reset values, sampled while reset is held low.
        #2;
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_out", 64'({out_valid, out_last, out_data}), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));

        // All inputs valid with single-beat packets: 0,1,2,3,0 with idle gaps.
        do_reset();
        for (int i = 0; i < N; i++) begin
            q[i].push_back({1'b1, 8'(8'h10 + i)});
            q[i].push_back({1'b1, 8'(8'h20 + i)});
        end
        en = 4'b1111;
        for (int r = 0; r < 10; r++) begin
            cyc(tbl[r].ordy);
            chk($sformatf("vec%0d_grant", r), 64'(grant), 64'(tbl[r].g));
            chk($sformatf("vec%0d_busy", r), 64'(busy), 64'(|tbl[r].g));
            chk($sformatf("vec%0d_ov", r), 64'(out_valid), 64'(tbl[r].ov));
            chk($sformatf("vec%0d_od", r), 64'(out_data), 64'(tbl[r].od));
        end

        // Three-beat packet on input 2 is not interleaved with input 1.
        do_reset();
        q[2].push_back({1'b0, 8'hA1});
        q[2].push_back({1'b0, 8'hA2});
        q[2].push_back({1'b1, 8'hA3});
        q[1].push_back({1'b1, 8'hB1});
        en = 4'b0100;
        cyc(1'b1);
        chk("pkt_grant2", 64'(grant), 64'(4'b0100));
        en = 4'b0110;
        for (int c = 0; c < 10; c++) cyc(1'b1);
        chk("pkt_len", 64'(log_q.size()), 64'(4));
        if (log_q.size() == 4) begin
            chk("pkt_order", 64'({log_q[0], log_q[1], log_q[2], log_q[3]}), 64'(32'hA1A2A3B1));
            chk("pkt_back_to_back", 64'({stamp[1] - stamp[0], stamp[2] - stamp[0]}), 64'({32'd1, 32'd2}));
        end

        // Downstream stall for five cycles mid-packet.
        do_reset();
        q[0].push_back({1'b0, 8'hC1});
        q[0].push_back({1'b0, 8'hC2});
        q[0].push_back({1'b0, 8'hC3});
        q[0].push_back({1'b1, 8'hC4});
        en = 4'b0001;
        cyc(1'b1); cyc(1'b1); cyc(1'b1);
        for (int c = 0; c < 5; c++) begin
            cyc(1'b0);
            chk("stall_hold", 64'({out_valid, out_data, in_ready}), 64'({1'b1, 8'hC2, 4'b0000}));
        end
        for (int c = 0; c < 6; c++) cyc(1'b1);
        chk("stall_len", 64'(log_q.size()), 64'(4));
        if (log_q.size() == 4)
            chk("stall_order", 64'({log_q[0], log_q[1], log_q[2], log_q[3]}), 64'(32'hC1C2C3C4));

        // Only input 3 valid: search wraps around and grants 3 again.
        do_reset();
        en = 4'b1000;
        q[3].push_back({1'b1, 8'hD1});
        cyc(1'b1);
        chk("wrap_grant_a", 64'(grant), 64'(4'b1000));
        cyc(1'b1); cyc(1'b1); cyc(1'b1);
        q[3].push_back({1'b1, 8'hD2});
        cyc(1'b1);
        chk("wrap_grant_b", 64'(grant), 64'(4'b1000));
        cyc(1'b1); cyc(1'b1);
        chk("wrap_out", 64'(out_data), 64'(8'hD2));

        // Asynchronous reset mid-packet, then input 0 is favoured.
        do_reset();
        q[2].push_back({1'b0, 8'hE1});
        q[2].push_back({1'b0, 8'hE2});
        q[2].push_back({1'b1, 8'hE3});
        en = 4'b0100;
        cyc(1'b1); cyc(1'b1); cyc(1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_rst", 64'({out_valid, grant, busy}), 64'(0));
        do_reset();
        q[0].push_back({1'b1, 8'hF0});
        q[1].push_back({1'b1, 8'hF1});
        en = 4'b0011;
        cyc(1'b1);
        chk("rst_favour0", 64'(grant), 64'(4'b0001));
        for (int c = 0; c < 6; c++) cyc(1'b1);
        chk("rst_after_len", 64'(log_q.size()), 64'(2));
        if (log_q.size() == 2) chk("rst_after_order", 64'({log_q[0], log_q[1]}), 64'(16'hF0F1));

        // Random traffic against the model and scoreboard.
        do_reset();
        for (int i = 0; i < N; i++) begin gen_seq[i] = '0; exp_seq[i] = '0; starve[i] = 0; end
        cur_src = -1;
        sb_on = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (q[i].size() < 3 && $urandom_range(0, 3) == 0) push_pkt(i, int'($urandom_range(1, 4)));
                en[i] = ($urandom_range(0, 9) != 0);
            end
            cyc($urandom_range(0, 9) < 7);
        end
        en = 4'b1111;
        for (int c = 0; c < 80; c++) cyc(1'b1);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("drain_q%0d", i), 64'(q[i].size()), 64'(0));
            chk($sformatf("drain_seq%0d", i), 64'(exp_seq[i]), 64'(gen_seq[i]));
        end
        chk("drain_pkt_closed", 64'(cur_src == -1), 64'(1));
        sb_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
